konix_p88_loader: RTL
=====================

Name: konix_p88_loader

Overview:
- Standalone sequencer that parses the P88 program stream from the HPS ioctl interface.
- Holds the Konix system in reset while a download is in progress.
- Writes section payloads into DRAM and patches the ROM reset vector with a far JMP to the program entry point.
- Sits between the ioctl download port and the DRAM/ROM write muxes; owns the RAM address/data bus only while hold_reset=1.

Parameters:
- ADDR_W, 20, physical address width; seg*16+off arithmetic wraps modulo 2^ADDR_W.
- ROM_AW, 3, ROM patch address width; the 5-byte JMP must fit, so ROM_AW>=3.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- ioctl_download  in  1  download window active.
- ioctl_wr  in  1  one-cycle strobe, ioctl_dout valid.
- ioctl_dout  in  8  stream byte.
- ioctl_wait  out  1  backpressure to the HPS; no ioctl_wr may arrive while it is high.
- hold_reset  out  1  system reset request; also selects the loader as RAM bus master.
- mem_addr  out  ADDR_W  write address (DRAM byte address, or ROM offset in the low ROM_AW bits).
- mem_data  out  8  write data.
- mem_wr_dram  out  1  DRAM write request, held until acked.
- mem_wr_rom  out  1  ROM write request, held until acked.
- mem_ack  in  1  write accepted; sampled only while a request is high.
- load_done  out  1  one-cycle pulse on a clean end of download.
- load_error  out  1  sticky until the next download starts.
- sections  out  8  count of completed C8 sections, saturating at 255.

Behaviour:
- Reset (async):
  - States: S_IDLE.
  - Outputs: all outputs 0; mem_addr=0; sections=0.
  - Internal regs: seg, off, len = 0.
- Edge detection: ioctl_download is registered each cycle.
  - Rising edge: hold_reset<=1, load_error<=0, sections<=0, state<=S_CMD.
  - Falling edge: hold_reset<=0 on the next cycle.
    - load_done pulses for one cycle if state==S_CMD and !load_error.
    - Otherwise (truncated record): load_error<=1, no load_done.
    - Then state<=S_IDLE, and any pending write request is dropped.
- Bytes are consumed only on ioctl_wr while !ioctl_wait. A strobe while ioctl_wait=1 is ignored and sets load_error.
- States:
  - S_IDLE: ignore all bytes.
  - S_CMD:
    - 0xC8 -> S_C8 hdr, 8 bytes counted by hdr_idx: segL segH offL offH skip skip lenL lenH.
    - 0xCA -> S_CA hdr, 4 bytes: segL segH offL offH.
    - Any other byte -> load_error<=1, S_ERR.
  - S_C8 hdr, after lenH:
    - addr <= ({seg,4'b0}+off) mod 2^ADDR_W.
    - len==0: sections++ and return to S_CMD.
    - Else -> S_DATA.
  - S_DATA:
    - On byte at cycle N: cycle N+1 mem_data=byte, mem_addr=addr, mem_wr_dram=1, ioctl_wait=1 -> S_WACK.
  - S_WACK:
    - Hold the request until mem_ack=1 (ack in the first request cycle is allowed).
    - Cycle after ack: mem_wr_dram=0, ioctl_wait=0, addr+1 (wraps), len-1.
    - If new len==0: sections++ -> S_CMD; else -> S_DATA.
    - Minimum 2 cycles per byte.
  - S_CA, after offH:
    - ioctl_wait<=1 -> S_ROM, patch_idx=0..4.
    - Bytes written: 0xEA, offL, offH, segL, segH at ROM offsets 0..4, each using the same req/ack handshake on mem_wr_rom.
    - After the 5th ack: ioctl_wait<=0 -> S_CMD.
  - S_ERR: swallow bytes until the falling edge of ioctl_download.
- A second CA record overwrites the patch (last wins).
- mem_wr_dram and mem_wr_rom are never high together; neither is ever high while hold_reset=0.
- Reset mid-operation: immediate return to reset values, including ioctl_wait=0.
- Arithmetic:
  - len is 16 bits.
  - Address add is done at ADDR_W+1 bits and truncated.

Decomposition:
- Package konix_loader_pkg: CMD_SECTION=8'hC8, CMD_ENTRY=8'hCA, OP_JMPF=8'hEA, state enum, header byte counts (8, 4), JMP length 5.
- One natural sub-module, konix_wr_port: req/ack write handshake (latch addr/data, hold request, done pulse), shared by the DRAM and ROM paths with a target select.

Test Plan:
- C8, seg=0x1000, off=0x0010, len=3, data AA BB CC, mem_ack tied 1 -> DRAM writes AA@0x10010, BB@0x10011, CC@0x10012; sections=1; load_done pulse; hold_reset 1 during the window, 0 one cycle after download falls.
- CA, seg=0x1234, off=0x5678 -> ROM writes EA,78,56,34,12 at offsets 0..4; ioctl_wait high from the cycle after offH until the cycle after the 5th ack.
- C8, seg=0xFFFF, off=0x0010, len=2 -> writes at 0x00000 and 0x00001 (wrap); mem_ack delayed 3 cycles -> requests held 3 cycles, ioctl_wait stays high.
- Command byte 0x55 -> load_error=1; following bytes produce no writes; no load_done; load_error clears on the next download rising edge.
- Download falls after 2 of 4 data bytes -> load_error=1, no load_done, no further writes, hold_reset=0.
- Async reset during S_WACK -> mem_wr_dram, ioctl_wait, and hold_reset go 0 immediately; state S_IDLE.

Source files
------------

// File: rtl/konix_loader_pkg.sv
// Shared constants and state encoding for the Konix P88 program loader.
package konix_loader_pkg;

   localparam logic [7:0] CMD_SECTION = 8'hC8;
   localparam logic [7:0] CMD_ENTRY   = 8'hCA;
   localparam logic [7:0] OP_JMPF     = 8'hEA;

   localparam int C8_HDR_LEN = 8;
   localparam int CA_HDR_LEN = 4;
   localparam int JMP_LEN    = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_C8,
      S_CA,
      S_DATA,
      S_WACK,
      S_ROM,
      S_ERR
   } state_t;

endpackage

// File: rtl/konix_wr_port.sv
// Single-outstanding write port: latches address/data on start and holds the
// request to the selected target (DRAM or ROM) until the memory acknowledges.
module konix_wr_port #(
   parameter int ADDR_W = 20
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              sel_rom,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        data,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_wr_dram,
   output logic              mem_wr_rom,
   output logic              done
);

   logic req;
   logic is_rom;

   // A start in the same cycle as an ack chains the next write without a gap.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         req      <= 1'b0;
         is_rom   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else if (abort) begin
         req <= 1'b0;
      end else if (start) begin
         req      <= 1'b1;
         is_rom   <= sel_rom;
         mem_addr <= addr;
         mem_data <= data;
      end else if (req && mem_ack) begin
         req <= 1'b0;
      end
   end

   assign done        = req & mem_ack;
   assign mem_wr_dram = req & ~is_rom;
   assign mem_wr_rom  = req & is_rom;

endmodule

// File: rtl/konix_p88_loader.sv
// P88 stream parser: holds the system in reset during download, writes C8
// section payloads to DRAM and patches the ROM reset vector from CA records.
module konix_p88_loader
   import konix_loader_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int ROM_AW = 3
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic              hold_reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_wr_dram,
   output logic              mem_wr_rom,
   input  logic              mem_ack,
   output logic              load_done,
   output logic              load_error,
   output logic [7:0]        sections
);

   state_t            state, state_nxt;
   logic              dl_q, dl_rise, dl_fall, byte_ok;
   logic [2:0]        hdr_idx;
   logic [ROM_AW-1:0] patch_idx, patch_nxt;
   logic [15:0]       seg, off, len, len_hdr;
   logic [ADDR_W-1:0] addr, sec_addr, wr_addr;
   logic [7:0]        wr_data, jmp_byte;
   logic              wr_start, wr_rom, wr_done;

   assign dl_rise   = ioctl_download & ~dl_q;
   assign dl_fall   = ~ioctl_download & dl_q;
   assign byte_ok   = ioctl_wr & ~ioctl_wait;
   assign len_hdr   = {ioctl_dout, len[7:0]};
   assign sec_addr  = ADDR_W'({seg, 4'b0000}) + ADDR_W'(off);
   assign patch_nxt = patch_idx + ROM_AW'(1);

   // Far JMP image: opcode, offset, segment (little-endian).
   always_comb begin
      jmp_byte = OP_JMPF;
      case (patch_nxt)
         ROM_AW'(1): jmp_byte = off[7:0];
         ROM_AW'(2): jmp_byte = off[15:8];
         ROM_AW'(3): jmp_byte = seg[7:0];
         ROM_AW'(4): jmp_byte = seg[15:8];
         default:    jmp_byte = OP_JMPF;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_start  = 1'b0;
      wr_rom    = 1'b0;
      wr_addr   = addr;
      wr_data   = ioctl_dout;
      if (dl_rise) begin
         state_nxt = S_CMD;
      end else if (dl_fall) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_CMD:
               if (byte_ok) begin
                  if (ioctl_dout == CMD_SECTION)    state_nxt = S_C8;
                  else if (ioctl_dout == CMD_ENTRY) state_nxt = S_CA;
                  else                              state_nxt = S_ERR;
               end
            S_C8:
               if (byte_ok && hdr_idx == 3'(C8_HDR_LEN - 1))
                  state_nxt = (len_hdr == 16'd0) ? S_CMD : S_DATA;
            S_CA:
               if (byte_ok && hdr_idx == 3'(CA_HDR_LEN - 1)) begin
                  state_nxt = S_ROM;
                  wr_start  = 1'b1;
                  wr_rom    = 1'b1;
                  wr_addr   = '0;
                  wr_data   = OP_JMPF;
               end
            S_DATA:
               if (byte_ok) begin
                  state_nxt = S_WACK;
                  wr_start  = 1'b1;
               end
            S_WACK:
               if (wr_done) state_nxt = (len == 16'd1) ? S_CMD : S_DATA;
            S_ROM:
               if (wr_done) begin
                  if (patch_idx == ROM_AW'(JMP_LEN - 1)) begin
                     state_nxt = S_CMD;
                  end else begin
                     wr_start = 1'b1;
                     wr_rom   = 1'b1;
                     wr_addr  = ADDR_W'(patch_nxt);
                     wr_data  = jmp_byte;
                  end
               end
            default: state_nxt = state;
         endcase
      end
   end

   // Header capture, address/length bookkeeping and status flags.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dl_q       <= 1'b0;
         hold_reset <= 1'b0;
         ioctl_wait <= 1'b0;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         sections   <= '0;
         hdr_idx    <= '0;
         patch_idx  <= '0;
         seg        <= '0;
         off        <= '0;
         len        <= '0;
         addr       <= '0;
      end else begin
         dl_q      <= ioctl_download;
         load_done <= 1'b0;
         if (ioctl_wr && ioctl_wait) load_error <= 1'b1;
         if (dl_rise) begin
            hold_reset <= 1'b1;
            ioctl_wait <= 1'b0;
            load_error <= 1'b0;
            sections   <= '0;
            hdr_idx    <= '0;
         end else if (dl_fall) begin
            hold_reset <= 1'b0;
            ioctl_wait <= 1'b0;
            if (state == S_CMD && !load_error) load_done  <= 1'b1;
            else                               load_error <= 1'b1;
         end else begin
            case (state)
               S_CMD:
                  if (byte_ok) begin
                     hdr_idx <= '0;
                     if (ioctl_dout != CMD_SECTION && ioctl_dout != CMD_ENTRY)
                        load_error <= 1'b1;
                  end
               S_C8, S_CA:
                  if (byte_ok) begin
                     hdr_idx <= hdr_idx + 3'd1;
                     case (hdr_idx)
                        3'd0: seg[7:0]  <= ioctl_dout;
                        3'd1: seg[15:8] <= ioctl_dout;
                        3'd2: off[7:0]  <= ioctl_dout;
                        3'd3: off[15:8] <= ioctl_dout;
                        3'd6: len[7:0]  <= ioctl_dout;
                        default: ;
                     endcase
                     if (state == S_CA && hdr_idx == 3'(CA_HDR_LEN - 1)) begin
                        ioctl_wait <= 1'b1;
                        patch_idx  <= '0;
                     end
                     if (state == S_C8 && hdr_idx == 3'(C8_HDR_LEN - 1)) begin
                        len  <= len_hdr;
                        addr <= sec_addr;
                        if (len_hdr == 16'd0 && sections != 8'hFF)
                           sections <= sections + 8'd1;
                     end
                  end
               S_DATA:
                  if (byte_ok) ioctl_wait <= 1'b1;
               S_WACK:
                  if (wr_done) begin
                     ioctl_wait <= 1'b0;
                     addr       <= addr + ADDR_W'(1);
                     len        <= len - 16'd1;
                     if (len == 16'd1 && sections != 8'hFF)
                        sections <= sections + 8'd1;
                  end
               S_ROM:
                  if (wr_done) begin
                     if (patch_idx == ROM_AW'(JMP_LEN - 1)) ioctl_wait <= 1'b0;
                     else                                   patch_idx  <= patch_nxt;
                  end
               default: ;
            endcase
         end
      end
   end

   konix_wr_port #(.ADDR_W(ADDR_W)) u_wr_port (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .start       (wr_start),
      .abort       (dl_fall),
      .sel_rom     (wr_rom),
      .addr        (wr_addr),
      .data        (wr_data),
      .mem_ack     (mem_ack),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_wr_dram (mem_wr_dram),
      .mem_wr_rom  (mem_wr_rom),
      .done        (wr_done)
   );

endmodule
